alu_issue_ctrl: RTL and testbench

Upstream issue/writeback stage for the combinational 16-bit ALU (alu16bit). Accepts one command per handshake, reads operands from an 8x16 register file (or an immediate), and drives the ALU's a/b/operation inputs from registers. Captures S/overflow/zero and writes the result back to the register file and a flag register. Sits between the command source (test sequencer or future decoder) and alu16bit.

---
 rtl/alu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for alu16bit: regfile read, ALU drive, result/flag capture.
// Optional STICKY_OVF_EN: overflow flag accumulates across legal ops until flag_clr.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [2:0]        cmd_rd,
    input  logic [2:0]        cmd_ra,
    input  logic [2:0]        cmd_rb,
    input  logic              cmd_imm_sel,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_operation,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic              flag_clr,
    output logic              flag_overflow,
    output logic              flag_zero,
    output logic              done,
    output logic              err,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]                   state;
    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]            res_q;
    logic [2:0]                   rd_q;
    logic                         accept;
    logic                         wb_fwd;
    logic [DATA_W-1:0]            ra_val;
    logic [DATA_W-1:0]            rb_val;
    logic [DATA_W-1:0]            b_next;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0111, 4'b1011, 4'b1101, 4'b1111: op_legal = 1'b0;
            default:                            op_legal = 1'b1;
        endcase
    endfunction

    function automatic logic op_unary(input logic [3:0] op);
        op_unary = (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0110);
    endfunction

    assign cmd_ready = (state != S_EXEC);
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_data  = regs[dbg_addr];

    // Forward only what is actually about to be written: an illegal op in WB writes nothing.
    assign wb_fwd = (state == S_WB) && (rd_q != 3'd0) && !err;
    assign ra_val = (wb_fwd && cmd_ra == rd_q) ? res_q : regs[cmd_ra];
    assign rb_val = (wb_fwd && cmd_rb == rd_q) ? res_q : regs[cmd_rb];
    assign b_next = op_unary(cmd_op) ? '0 : (cmd_imm_sel ? cmd_imm : rb_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            regs          <= '0;
            res_q         <= '0;
            rd_q          <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= '0;
            flag_overflow <= 1'b0;
            flag_zero     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_EXEC: begin
                    res_q <= alu_s;
                    done  <= 1'b1;
                    err   <= !op_legal(alu_operation);
                    if (op_legal(alu_operation)) begin
                        flag_zero <= alu_zero;
`ifdef STICKY_OVF_EN
                        flag_overflow <= flag_overflow | alu_overflow;
`else
                        flag_overflow <= alu_overflow;
`endif
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    if (!err && rd_q != 3'd0)
                        regs[rd_q] <= res_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Accept overrides the IDLE/WB next-state above.
            if (accept) begin
                alu_a         <= ra_val;
                alu_b         <= b_next;
                alu_operation <= cmd_op;
                rd_q          <= cmd_rd;
                state         <= S_EXEC;
            end
`ifdef STICKY_OVF_EN
            if (flag_clr)
                flag_overflow <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural alu16bit stand-in.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
    logic        cmd_imm_sel;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_operation;
    logic        alu_overflow, alu_zero;
    logic        flag_clr;
    logic        flag_overflow, flag_zero;
    logic        done, err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int d0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
        .alu_s(alu_s), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .flag_clr(flag_clr), .flag_overflow(flag_overflow), .flag_zero(flag_zero),
        .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in for the opcodes this bench exercises; anything else yields a junk result.
    always_comb begin
        alu_s        = 16'hdead;
        alu_overflow = 1'b0;
        case (alu_operation)
            4'b0000: begin
                alu_s        = alu_a - alu_b;
                alu_overflow = (alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'b0001: begin
                alu_s        = alu_a + alu_b;
                alu_overflow = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'b0100: begin alu_s = alu_a - 16'd1; alu_overflow = (alu_a == 16'h8000); end
            4'b0101: begin alu_s = alu_a + 16'd1; alu_overflow = (alu_a == 16'h7fff); end
            4'b0110: begin alu_s = 16'd0 - alu_a; alu_overflow = (alu_a == 16'h8000); end
            4'b1110: alu_s = $signed(alu_a) >>> alu_b[3:0];
            default: ;
        endcase
        alu_zero = (alu_s == 16'd0);
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("reg r%0d", a), dbg_data, exp);
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic sel, input logic [15:0] imm);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_imm_sel = sel; cmd_imm = imm;
    endtask

    // Issue at a negedge; returns at the negedge inside WB.
    task automatic run(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic sel, input logic [15:0] imm,
                       input logic [15:0] ea, input logic [15:0] eb);
        drive(op, rd, ra, rb, sel, imm);
        chk("ready before accept", cmd_ready, 1);
        step;
        cmd_valid = 1'b0;
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_operation", alu_operation, op);
        chk("ready in exec", cmd_ready, 0);
        chk("done in exec", done, 0);
        step;
        chk("done in wb", done, 1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_imm_sel = 1'b0; cmd_imm = '0; flag_clr = 1'b0; dbg_addr = '0;
        @(negedge clk); @(negedge clk);
        chk("reset ready", cmd_ready, 1);
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_b", alu_b, 0);
        chk("reset op", alu_operation, 0);
        chk("reset ovf", flag_overflow, 0);
        chk("reset zero", flag_zero, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        rst_n = 1'b1;
        step;

        // Loads
        run(4'b0001, 3'd1, 3'd0, 3'd0, 1'b1, 16'h2345, 16'h0000, 16'h2345);
        chk("load1 err", err, 0);
        step;
        chk("done after wb", done, 0);
        chk_reg(3'd1, 16'h2345);
        run(4'b0001, 3'd2, 3'd0, 3'd0, 1'b1, 16'h1111, 16'h0000, 16'h1111);
        step;
        chk_reg(3'd2, 16'h1111);
        chk("done count", 16'(done_cnt), 16'd2);

        // Subtract
        run(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h2345, 16'h1111);
        chk("sub zero", flag_zero, 0);
        chk("sub ovf", flag_overflow, 0);
        step;
        chk_reg(3'd3, 16'h1234);
        run(4'b0000, 3'd4, 3'd3, 3'd3, 1'b0, 16'h0000, 16'h1234, 16'h1234);
        chk("sub self zero", flag_zero, 1);
        step;
        chk_reg(3'd4, 16'h0000);

        // Back-to-back with bypass; inc forces b to 0 despite imm
        run(4'b0001, 3'd5, 3'd0, 3'd0, 1'b1, 16'h7fff, 16'h0000, 16'h7fff);
        run(4'b0101, 3'd5, 3'd5, 3'd5, 1'b1, 16'h1234, 16'h7fff, 16'h0000);
        chk("inc ovf", flag_overflow, 1);
        chk("inc zero", flag_zero, 0);
        step;
        chk_reg(3'd5, 16'h8000);

        // Arithmetic shift
        run(4'b0001, 3'd6, 3'd0, 3'd0, 1'b1, 16'h8000, 16'h0000, 16'h8000);
        step;
        run(4'b1110, 3'd6, 3'd6, 3'd0, 1'b1, 16'h000f, 16'h8000, 16'h000f);
        step;
        chk_reg(3'd6, 16'hffff);

        // r0 write ignored
        run(4'b0001, 3'd0, 3'd0, 3'd0, 1'b1, 16'h5555, 16'h0000, 16'h5555);
        step;
        chk_reg(3'd0, 16'h0000);

        // Set both flags, then illegal op must leave them alone
        run(4'b0001, 3'd7, 3'd5, 3'd5, 1'b0, 16'h0000, 16'h8000, 16'h8000);
        chk("pre ovf", flag_overflow, 1);
        chk("pre zero", flag_zero, 1);
        step;
        run(4'b0111, 3'd1, 3'd2, 3'd0, 1'b1, 16'h0000, 16'h1111, 16'h0000);
        chk("illegal err", err, 1);
        chk("illegal ovf kept", flag_overflow, 1);
        chk("illegal zero kept", flag_zero, 1);
        step;
        chk("err pulse end", err, 0);
        chk("done pulse end", done, 0);
        chk_reg(3'd1, 16'h2345);

        // Reset during EXEC
        d0 = done_cnt;
        drive(4'b0001, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0042);
        step;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort ready", cmd_ready, 1);
        chk("abort alu_a", alu_a, 0);
        chk("abort alu_b", alu_b, 0);
        chk("abort ovf", flag_overflow, 0);
        chk("abort zero", flag_zero, 0);
        step; step;
        rst_n = 1'b1;
        step; step;
        chk("abort no done", 16'(done_cnt), 16'(d0));
        chk("abort ready after", cmd_ready, 1);
        chk_reg(3'd7, 16'h0000);
        chk_reg(3'd1, 16'h0000);

        // Overflow flag across ops and flag_clr
        run(4'b0001, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7fff, 16'h0000, 16'h7fff);
        step;
        run(4'b0101, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0000, 16'h7fff, 16'h0000);
        chk("ovf set", flag_overflow, 1);
        step;
`ifdef STICKY_OVF_EN
        run(4'b0001, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0001, 16'h0000, 16'h0001);
        chk("sticky ovf held", flag_overflow, 1);
        step;
        flag_clr = 1'b1;
        step;
        flag_clr = 1'b0;
        chk("sticky ovf cleared", flag_overflow, 0);
`else
        flag_clr = 1'b1;
        step;
        flag_clr = 1'b0;
        chk("clr ignored", flag_overflow, 1);
        run(4'b0001, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0001, 16'h0000, 16'h0001);
        chk("ovf follows last op", flag_overflow, 0);
        step;
`endif
        chk_reg(3'd2, 16'h8000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
